overlay_scheduler: RTL and testbench

Frame-synchronous controller that owns a small bank of drawable overlay primitives (pixel, square, rectangle) and time-shares the pixel datapath between them for the 640x480 HDMI path. Shape commands arrive over a valid/ready handshake into a shadow bank. The shadow bank is committed to the active bank only at frame start, so a frame never tears. Each active pixel is resolved through a 2-stage pipeline: per-slot hit test, then fixed-priority select against the background colour.

---
 rtl/overlay_scheduler_pkg.sv | 25 ++
 rtl/overlay_scheduler_hit.sv | 40 ++++
 rtl/overlay_scheduler.sv | 119 +++++++++++
 tb/tb_overlay_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/overlay_scheduler_pkg.sv
// rtl/overlay_scheduler_pkg.sv - shared shape types and frame constants for the overlay scheduler
package overlay_package;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 24;
    localparam int H_RES   = 640;
    localparam int V_RES   = 480;

    typedef enum logic [1:0] {
        DISABLE   = 2'd0,
        PIXEL     = 2'd1,
        SQUARE    = 2'd2,
        RECTANGLE = 2'd3
    } shape_kind_e;

    typedef struct packed {
        shape_kind_e          kind;
        logic [COORD_W-1:0]   x;
        logic [COORD_W-1:0]   y;
        logic [COORD_W-1:0]   w;
        logic [COORD_W-1:0]   h;
        logic [COLOR_W-1:0]   color;
    } shape_t;

endpackage

// File: rtl/overlay_scheduler_hit.sv
// rtl/overlay_scheduler_hit.sv - combinational inclusive-bounds hit test of one shape against a pixel
module overlay_hit_unit #(
    parameter int COORD_W = overlay_package::COORD_W,
    parameter int H_RES   = overlay_package::H_RES,
    parameter int V_RES   = overlay_package::V_RES
) (
    input  overlay_package::shape_t shape,
    input  logic [COORD_W-1:0]      pos_x,
    input  logic [COORD_W-1:0]      pos_y,
    output logic                    hit
);
    import overlay_package::*;

    // One extra bit so x+w and y+h never wrap back onto the left/top edge.
    localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_RES);

    logic [COORD_W:0] px, py, x0, y0, x1, y1, ext_y;
    logic             on_screen, in_box;

    assign px        = {1'b0, pos_x};
    assign py        = {1'b0, pos_y};
    assign x0        = {1'b0, shape.x};
    assign y0        = {1'b0, shape.y};
    assign ext_y     = (shape.kind == SQUARE) ? {1'b0, shape.w} : {1'b0, shape.h};
    assign x1        = x0 + {1'b0, shape.w};
    assign y1        = y0 + ext_y;
    assign on_screen = (x0 < H_LIM) && (y0 < V_LIM);
    assign in_box    = (px >= x0) && (px <= x1) && (py >= y0) && (py <= y1);

    always_comb begin
        hit = 1'b0;
        case (shape.kind)
            PIXEL:            hit = on_screen && (px == x0) && (py == y0);
            SQUARE, RECTANGLE: hit = on_screen && in_box;
            default:          hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/overlay_scheduler.sv
// rtl/overlay_scheduler.sv - shadow/active shape banks with frame-start commit and 2-stage pixel resolve
module overlay_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int COORD_W   = overlay_package::COORD_W,
    parameter int H_RES     = overlay_package::H_RES,
    parameter int V_RES     = overlay_package::V_RES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_slot,
    input  logic [1:0]         cmd_kind,
    input  logic [COORD_W-1:0] cmd_x,
    input  logic [COORD_W-1:0] cmd_y,
    input  logic [COORD_W-1:0] cmd_w,
    input  logic [COORD_W-1:0] cmd_h,
    input  logic [23:0]        cmd_color,
    input  logic [23:0]        bg_color,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    output logic [23:0]        rgb_out,
    output logic               rgb_valid,
    output logic               pending
);
    import overlay_package::*;

    shape_t                shadow   [NUM_SLOTS];
    shape_t                active   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  hits;
    logic                  s1_valid;
    logic [NUM_SLOTS-1:0]  s1_hit;
    logic [23:0]           s1_bg;
    logic [23:0]           s1_color [NUM_SLOTS];
    logic [23:0]           sel_color;
    logic                  cmd_fire;
    logic                  slot_ok;
    shape_t                cmd_shape;

    assign cmd_ready = !rst && !frame_start;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign slot_ok   = {1'b0, cmd_slot} < 4'(NUM_SLOTS);

    always_comb begin
        cmd_shape       = '0;
        cmd_shape.kind  = shape_kind_e'(cmd_kind);
        cmd_shape.x     = cmd_x;
        cmd_shape.y     = cmd_y;
        cmd_shape.w     = cmd_w;
        cmd_shape.h     = cmd_h;
        cmd_shape.color = cmd_color;
    end

    // Commit and command transfer never coincide because cmd_ready drops during frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            pending <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (cmd_fire && cmd_slot == 3'(i))
                    shadow[i] <= cmd_shape;
                if (frame_start && pending)
                    active[i] <= shadow[i];
            end
            if (cmd_fire && slot_ok)
                pending <= 1'b1;
            else if (frame_start && pending)
                pending <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
        overlay_hit_unit #(
            .COORD_W (COORD_W),
            .H_RES   (H_RES),
            .V_RES   (V_RES)
        ) u_hit (
            .shape (active[g]),
            .pos_x (pos_x),
            .pos_y (pos_y),
            .hit   (hits[g])
        );
    end

    // Colours are captured with the hits so a commit between stages cannot mix banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_hit   <= '0;
            s1_bg    <= '0;
            for (int i = 0; i < NUM_SLOTS; i++)
                s1_color[i] <= '0;
            rgb_out   <= '0;
            rgb_valid <= 1'b0;
        end else begin
            s1_valid <= pix_valid;
            s1_hit   <= hits;
            s1_bg    <= bg_color;
            for (int i = 0; i < NUM_SLOTS; i++)
                s1_color[i] <= active[i].color;
            rgb_out   <= sel_color;
            rgb_valid <= s1_valid;
        end
    end

    always_comb begin
        sel_color = s1_bg;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (s1_hit[i])
                sel_color = s1_color[i];
    end

endmodule

// File: tb/tb_overlay_scheduler.sv
// tb/tb_overlay_scheduler.sv - directed self-checking bench for overlay_scheduler
module tb_overlay_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_slot = '0;
    logic [1:0]  cmd_kind = '0;
    logic [9:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    logic [23:0] cmd_color = '0;
    logic [23:0] bg_color = '0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  pos_x = '0, pos_y = '0;
    logic [23:0] rgb_out;
    logic        rgb_valid;
    logic        pending;

    int compared = 0;
    int mismatched = 0;

    localparam logic [23:0] BG = 24'h101010;

    overlay_scheduler #(.NUM_SLOTS(4), .COORD_W(10), .H_RES(640), .V_RES(480)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_slot    (cmd_slot),
        .cmd_kind    (cmd_kind),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_color   (cmd_color),
        .bg_color    (bg_color),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .rgb_out     (rgb_out),
        .rgb_valid   (rgb_valid),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] slot, input logic [1:0] kind,
                            input logic [9:0] x, input logic [9:0] y,
                            input logic [9:0] w, input logic [9:0] h,
                            input logic [23:0] color);
        cmd_slot  = slot;
        cmd_kind  = kind;
        cmd_x     = x;
        cmd_y     = y;
        cmd_w     = w;
        cmd_h     = h;
        cmd_color = color;
        cmd_valid = 1'b1;
        #1;
        chk("cmd_ready_before_write", {31'b0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y, input logic [23:0] exp);
        pos_x     = x;
        pos_y     = y;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        tick();
        chk({tag, "_valid"}, {31'b0, rgb_valid}, 32'd1);
        chk(tag, {8'b0, rgb_out}, {8'b0, exp});
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_rgb_out", {8'b0, rgb_out}, 32'd0);
        chk("rst_rgb_valid", {31'b0, rgb_valid}, 32'd0);
        chk("rst_pending", {31'b0, pending}, 32'd0);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'b0, cmd_ready}, 32'd1);

        bg_color = BG;
        pix("bg_origin", 10'd0, 10'd0, BG);
        chk("pending_idle", {31'b0, pending}, 32'd0);

        // Square in slot 1, visible only after commit
        send_cmd(3'd1, 2'd2, 10'd100, 10'd100, 10'd20, 10'd0, 24'hFF0000);
        chk("pending_after_write", {31'b0, pending}, 32'd1);
        pix("sq_precommit", 10'd110, 10'd110, BG);
        frame();
        chk("pending_after_commit", {31'b0, pending}, 32'd0);
        pix("sq_inside", 10'd110, 10'd110, 24'hFF0000);
        pix("sq_corner", 10'd120, 10'd120, 24'hFF0000);
        pix("sq_outside", 10'd121, 10'd120, BG);

        // Priority: slot 0 rectangle over slot 2 pixel
        send_cmd(3'd0, 2'd3, 10'd0, 10'd0, 10'd639, 10'd0, 24'h00FF00);
        send_cmd(3'd2, 2'd1, 10'd5, 10'd0, 10'd0, 10'd0, 24'h0000FF);
        frame();
        pix("prio_overlap", 10'd5, 10'd0, 24'h00FF00);
        pix("prio_row1", 10'd5, 10'd1, BG);
        pix("rect_right_edge", 10'd639, 10'd0, 24'h00FF00);

        // Command held across frame_start
        cmd_slot = 3'd3; cmd_kind = 2'd1; cmd_x = 10'd7; cmd_y = 10'd7;
        cmd_w = 10'd0; cmd_h = 10'd0; cmd_color = 24'h123456;
        cmd_valid = 1'b1;
        frame_start = 1'b1;
        #1;
        chk("ready_in_frame_start", {31'b0, cmd_ready}, 32'd0);
        tick();
        frame_start = 1'b0;
        #1;
        chk("ready_after_frame_start", {31'b0, cmd_ready}, 32'd1);
        chk("pending_not_yet", {31'b0, pending}, 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("pending_held_cmd", {31'b0, pending}, 32'd1);
        pix("held_precommit", 10'd7, 10'd7, BG);
        chk("pending_still", {31'b0, pending}, 32'd1);

        // Pixel in the commit cycle sees the old bank, the next one the new bank
        frame_start = 1'b1;
        pix_valid = 1'b1; pos_x = 10'd7; pos_y = 10'd7;
        tick();
        frame_start = 1'b0;
        tick();
        pix_valid = 1'b0;
        chk("commit_cycle_valid", {31'b0, rgb_valid}, 32'd1);
        chk("commit_cycle_old_bank", {8'b0, rgb_out}, {8'b0, BG});
        tick();
        chk("post_commit_valid", {31'b0, rgb_valid}, 32'd1);
        chk("post_commit_new_bank", {8'b0, rgb_out}, 24'h123456);
        chk("pending_cleared", {31'b0, pending}, 32'd0);

        // Ignored slot, and an off-screen square that must not wrap
        send_cmd(3'd5, 2'd3, 10'd0, 10'd0, 10'd100, 10'd100, 24'hABCDEF);
        chk("pending_ignored_slot", {31'b0, pending}, 32'd0);
        send_cmd(3'd3, 2'd2, 10'd1020, 10'd10, 10'd10, 10'd0, 24'hABCDEF);
        frame();
        pix("no_wrap", 10'd2, 10'd12, BG);
        pix("ignored_slot_nohit", 10'd50, 10'd50, BG);

        // Reset pulsed within a continuous stream
        pix_valid = 1'b1; pos_x = 10'd110; pos_y = 10'd110;
        tick();
        tick();
        chk("stream_valid", {31'b0, rgb_valid}, 32'd1);
        chk("stream_color", {8'b0, rgb_out}, 24'hFF0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid0", {31'b0, rgb_valid}, 32'd0);
        chk("rst_mid_pending", {31'b0, pending}, 32'd0);
        tick();
        chk("rst_mid_valid1", {31'b0, rgb_valid}, 32'd0);
        tick();
        chk("rst_mid_resume_valid", {31'b0, rgb_valid}, 32'd1);
        chk("rst_mid_resume_bg", {8'b0, rgb_out}, {8'b0, BG});
        pix_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
